// File: rtl/haze_synth_pkg.sv
// haze_synth_pkg: shared constants and helpers for the haze synthesis datapath.
//   T_ONE     - transmission value meaning 1.0 (Q1.8)
//   RND       - rounding constant added before the FRAC shift
//   FRAC      - fractional bits of the transmission
//   CLAMP_LO/HI - output pixel range
package haze_synth_pkg;
  localparam int NUM_LANES = 3;   // r, g, b
  localparam int PIX_W     = 8;
  localparam int STAGES    = 3;
  localparam int T_ONE     = 256;
  localparam int RND       = 128;
  localparam int FRAC      = 8;
  localparam logic signed [10:0] CLAMP_LO = 11'sd0;
  localparam logic signed [10:0] CLAMP_HI = 11'sd255;

  typedef logic [NUM_LANES-1:0][PIX_W-1:0] pix_vec_t;

  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [10:0] v);
    if (v < CLAMP_LO)      return '0;
    else if (v > CLAMP_HI) return '1;
    else                   return v[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/haze_synth_ch.sv
// haze_synth_ch: one colour channel of I = A + round((J - A) * t_sat / 256).
//   clk, rst      - clock, async active-high reset (output register only)
//   en1/en2/en3   - per-stage load enables from the shared handshake control
//   j, a          - scene radiance and atmospheric light, Q8.0
//   t             - transmission, unsigned Q1.8 (saturated to 1.0 here)
//   pix           - hazy output pixel (stage-3 register)
module haze_synth_ch
  import haze_synth_pkg::*;
#(
  parameter int T_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1,
  input  logic             en2,
  input  logic             en3,
  input  logic [PIX_W-1:0] j,
  input  logic [PIX_W-1:0] a,
  input  logic [T_W-1:0]   t,
  output logic [PIX_W-1:0] pix
);
  logic        [8:0]       t_sat;
  logic signed [8:0]       d1;
  logic        [8:0]       t1;
  logic        [PIX_W-1:0] a1, a2;
  logic signed [18:0]      prod;
  logic signed [17:0]      p2;
  logic signed [17:0]      rnd;
  logic signed [17:0]      sh;
  logic signed [10:0]      sum;

  assign t_sat = (t > T_W'(T_ONE)) ? 9'(T_ONE) : t[8:0];

  // S1: difference and saturated transmission (no reset, data only)
  always_ff @(posedge clk) begin
    if (en1) begin
      d1 <= $signed({1'b0, j}) - $signed({1'b0, a});
      t1 <= t_sat;
      a1 <= a;
    end
  end

  // |d| <= 255, t <= 256 so the product fits 18 bits signed
  assign prod = 19'(d1) * 19'($signed({1'b0, t1}));

  // S2: multiply
  always_ff @(posedge clk) begin
    if (en2) begin
      p2 <= prod[17:0];
      a2 <= a1;
    end
  end

  // S3: round-half-up via +RND then floor shift, add A, clamp
  assign rnd = p2 + 18'(RND);
  assign sh  = rnd >>> FRAC;
  assign sum = 11'(sh) + $signed({3'b000, a2});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pix <= '0;
    else if (en3) pix <= clamp_pix(sum);
  end
endmodule

// File: rtl/haze_synth.sv
// haze_synth: forward haze model I = J*t + A*(1-t), 3-stage elastic pipeline.
//   clk, rst              - clock, async active-high reset
//   in_r/g/b, A_r/g/b, t  - pixel, atmospheric light, transmission
//   in_user               - sideband carried with the pixel
//   in_valid/in_ready     - upstream handshake
//   out_r/g/b, out_user   - hazy pixel and its sideband
//   out_valid/out_ready   - downstream handshake
//   pix_cnt               - pixels delivered downstream since reset (wraps)
module haze_synth
  import haze_synth_pkg::*;
#(
  parameter int T_W    = 9,
  parameter int USER_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  in_r,
  input  logic [PIX_W-1:0]  in_g,
  input  logic [PIX_W-1:0]  in_b,
  input  logic [PIX_W-1:0]  A_r,
  input  logic [PIX_W-1:0]  A_g,
  input  logic [PIX_W-1:0]  A_b,
  input  logic [T_W-1:0]    t,
  input  logic [USER_W-1:0] in_user,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PIX_W-1:0]  out_r,
  output logic [PIX_W-1:0]  out_g,
  output logic [PIX_W-1:0]  out_b,
  output logic [USER_W-1:0] out_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       pix_cnt
);
  logic [STAGES:1]   vld_pipe;
  logic              adv1, adv2, adv3;
  logic              en1, en2, en3;
  logic [USER_W-1:0] user1, user2;
  pix_vec_t          j_vec, a_vec, o_vec;

  // Stage k moves when empty or when its successor moves; no in_valid term
  assign adv3 = !vld_pipe[3] || out_ready;
  assign adv2 = !vld_pipe[2] || adv3;
  assign adv1 = !vld_pipe[1] || adv2;

  // Data loads only for real pixels so bubbles never disturb held outputs
  assign en1 = adv1 && in_valid;
  assign en2 = adv2 && vld_pipe[1];
  assign en3 = adv3 && vld_pipe[2];

  assign in_ready  = adv1;
  assign out_valid = vld_pipe[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      if (adv1) vld_pipe[1] <= in_valid;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
      if (adv3) vld_pipe[3] <= vld_pipe[2];
    end
  end

  always_ff @(posedge clk) begin
    if (en1) user1 <= in_user;
    if (en2) user2 <= user1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      out_user <= '0;
    else if (en3) out_user <= user2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         pix_cnt <= '0;
    else if (out_valid && out_ready) pix_cnt <= pix_cnt + 32'd1;
  end

  assign j_vec = {in_b, in_g, in_r};
  assign a_vec = {A_b, A_g, A_r};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_ch
    haze_synth_ch #(.T_W(T_W)) u_ch (
      .clk (clk),
      .rst (rst),
      .en1 (en1),
      .en2 (en2),
      .en3 (en3),
      .j   (j_vec[i]),
      .a   (a_vec[i]),
      .t   (t),
      .pix (o_vec[i])
    );
  end

  assign out_r = o_vec[0];
  assign out_g = o_vec[1];
  assign out_b = o_vec[2];
endmodule

// File: tb/tb_haze_synth.sv
// tb_haze_synth: directed checks of haze_synth plus a stalled random stream.
module tb_haze_synth;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic [7:0] A_r = '0, A_g = '0, A_b = '0;
  logic [8:0] t = '0;
  logic [1:0] in_user = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_r, out_g, out_b;
  logic [1:0] out_user;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [31:0] pix_cnt;

  int errors = 0;
  int checks = 0;

  haze_synth #(.T_W(9), .USER_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .A_r(A_r), .A_g(A_g), .A_b(A_b),
    .t(t), .in_user(in_user),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_user(out_user), .out_valid(out_valid), .out_ready(out_ready),
    .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: I = A + round((J-A)*t_sat/256), clamped
  function automatic logic [7:0] mdl(input int j, input int a, input int tt);
    int ts, q, v;
    ts = (tt > 256) ? 256 : tt;
    q  = ((j - a) * ts + 128) >>> 8;
    v  = a + q;
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    return v[7:0];
  endfunction

  // One pixel with out_ready high; expected values hand-computed by caller
  task automatic pix(input string tag,
                     input logic [7:0] jr, jg, jb, ar, ag, ab,
                     input logic [8:0] tt, input logic [1:0] u,
                     input logic [7:0] er, eg, eb);
    @(posedge clk); #1;
    in_r = jr; in_g = jg; in_b = jb; A_r = ar; A_g = ag; A_b = ab;
    t = tt; in_user = u; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;                 // acceptance edge
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_lat3"}, out_valid, 1);
    chk({tag, "_r"}, out_r, er);
    chk({tag, "_g"}, out_g, eg);
    chk({tag, "_b"}, out_b, eb);
    chk({tag, "_user"}, out_user, u);
  endtask

  initial begin
    logic [26:0] q[$];
    logic [26:0] cur, held, exp_px;
    logic        stalled;
    int          sent, rcvd, cyc, stale;
    logic [7:0]  jr, jg, jb, ar, ag, ab;
    logic [8:0]  tt;
    logic [1:0]  u;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",  out_valid, 0);
    chk("rst_r",    out_r, 0);
    chk("rst_user", out_user, 0);
    chk("rst_cnt",  pix_cnt, 0);
    rst = 1'b0;
    #1 chk("rst_rdy", in_ready, 1);

    // t=128: 200/100->150, 99/100->100, 10/30->20
    pix("p128", 8'd200, 8'd99, 8'd10, 8'd100, 8'd100, 8'd30, 9'd128, 2'b01, 8'd150, 8'd100, 8'd20);
    // t=256: 0/255->0, 255/0->255, 17/200->17
    pix("p256", 8'd0, 8'd255, 8'd17, 8'd255, 8'd0, 8'd200, 9'd256, 2'b10, 8'd0, 8'd255, 8'd17);
    // t=0: out = A
    pix("p0", 8'd50, 8'd255, 8'd0, 8'd77, 8'd0, 8'd255, 9'd0, 2'b11, 8'd77, 8'd0, 8'd255);
    // t=300 saturates to 1.0: out = J
    pix("psat", 8'd10, 8'd200, 8'd128, 8'd200, 8'd10, 8'd128, 9'd300, 2'b00, 8'd10, 8'd200, 8'd128);
    @(posedge clk); #1;
    chk("cnt4", pix_cnt, 4);

    // Three pixels in flight, then a one-cycle reset
    for (int i = 0; i < 3; i++) begin
      in_r = 8'(40 + i); in_g = 8'd1; in_b = 8'd2; A_r = 8'd9; A_g = 8'd9; A_b = 8'd9;
      t = 9'd64; in_user = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_cnt", pix_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("mrst_rdy", in_ready, 1);
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("mrst_stale", stale, 0);

    // Random stream of 64 with random out_ready and alternating sideband
    sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0; held = '0;
    while ((sent < 64 || rcvd < 64) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      cur = {out_valid, out_user, out_r, out_g, out_b};
      if (stalled) chk("hold", cur, held);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 64) begin
        jr = 8'($urandom_range(0, 255)); jg = 8'($urandom_range(0, 255));
        jb = 8'($urandom_range(0, 255)); ar = 8'($urandom_range(0, 255));
        ag = 8'($urandom_range(0, 255)); ab = 8'($urandom_range(0, 255));
        tt = 9'($urandom_range(0, 511));
        u  = (sent % 2 == 0) ? 2'b01 : 2'b10;
        in_r = jr; in_g = jg; in_b = jb; A_r = ar; A_g = ag; A_b = ab;
        t = tt; in_user = u; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious", q.size(), 1);
        else chk("stream", cur, q.pop_front());
        rcvd++;
      end
      stalled = out_valid && !out_ready;
      held = cur;
      if (in_valid && in_ready) begin
        exp_px = {1'b1, u, mdl(jr, ar, tt), mdl(jg, ag, tt), mdl(jb, ab, tt)};
        q.push_back(exp_px);
        sent++;
      end
    end
    chk("stream_sent", sent, 64);
    chk("stream_rcvd", rcvd, 64);
    chk("stream_left", q.size(), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("cnt64", pix_cnt, 64);
    chk("drain_vld", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
